// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control sequencer for the RV32I-subset core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the ALU
// and datapath selects, handshakes with memory and traps on bad encodings
// or memory requests that are never acknowledged.
module mc_ctrl_fsm #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        EQ,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic [2:0]  ALUctrl,
  output logic        alu_src_b,
  output logic [2:0]  imm_src,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic        retire,
  output logic        illegal,
  output logic        bus_err
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic          bus_err_q, bus_err_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       alu_funct_ok;
  logic [2:0] alu_op;
  logic       is_r, is_i, is_lw, is_sw, is_br, is_jal, is_lui, legal;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign funct7_b5         = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Map funct3 (and funct7[5] for register ops) onto the ALU operation code
  always_comb begin
    alu_funct_ok = 1'b1;
    alu_op       = 3'b000;
    case (funct3)
      3'b000:  alu_op = (opcode == OP_R && funct7_b5) ? 3'b001 : 3'b000;
      3'b111:  alu_op = 3'b010;
      3'b110:  alu_op = 3'b011;
      3'b010:  alu_op = 3'b101;
      default: alu_funct_ok = 1'b0;
    endcase
  end

  assign is_r   = (opcode == OP_R) && alu_funct_ok;
  assign is_i   = (opcode == OP_I) && alu_funct_ok;
  assign is_lw  = (opcode == OP_LW) && (funct3 == 3'b010);
  assign is_sw  = (opcode == OP_SW) && (funct3 == 3'b010);
  assign is_br  = (opcode == OP_BR) && (funct3[2:1] == 2'b00);
  assign is_jal = (opcode == OP_JAL);
  assign is_lui = (opcode == OP_LUI);
  assign legal  = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_lui;

  // Next-state, timeout and output decode; outputs are forced quiet while rst is high
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_src = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ALUctrl      = 3'b000;
    alu_src_b    = 1'b0;
    imm_src      = 3'b000;
    reg_write    = 1'b0;
    result_src   = 2'b00;
    retire       = 1'b0;
    illegal      = 1'b0;
    bus_err      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else if (is_jal) begin
          imm_src    = 3'b011;
          reg_write  = 1'b1;
          result_src = 2'b10;
          pc_write   = 1'b1;
          pc_src     = 1'b1;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end else if (is_lui) begin
          imm_src    = 3'b100;
          reg_write  = 1'b1;
          result_src = 2'b11;
          pc_write   = 1'b1;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_br) begin
          ALUctrl  = 3'b001;
          imm_src  = 3'b010;
          pc_write = 1'b1;
          pc_src   = EQ ^ funct3[0];
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          alu_src_b = 1'b1;
          imm_src   = is_sw ? 3'b001 : 3'b000;
          state_d   = S_MEM;
        end else if (is_i) begin
          ALUctrl   = alu_op;
          alu_src_b = 1'b1;
          state_d   = S_WB;
        end else begin
          ALUctrl = alu_op;
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_src = 1'b1;
        mem_we       = is_sw;
        if (mem_ack) begin
          if (is_sw) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        result_src = is_lw ? 2'b01 : 2'b00;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        illegal = illegal_q;
        bus_err = bus_err_q;
      end
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_src = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      ALUctrl      = 3'b000;
      alu_src_b    = 1'b0;
      imm_src      = 3'b000;
      reg_write    = 1'b0;
      result_src   = 2'b00;
      retire       = 1'b0;
      illegal      = 1'b0;
      bus_err      = 1'b0;
    end
  end

  // State, timeout counter and sticky trap cause registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: self-checking bench for mc_ctrl_fsm with a per-cycle
// behavioural reference and directed literal checks of key latencies.
module tb_mc_ctrl_fsm;

  localparam int TIMEOUT = 16;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_JAL = 5, C_LUI = 6, C_BAD = 7;
  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_TRAP = 5;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_src;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [2:0] alu;
    logic       alu_src_b;
    logic [2:0] imm;
    logic       reg_write;
    logic [1:0] res;
    logic       retire;
    logic       illegal;
    logic       bus_err;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        EQ;
  logic        mem_ack;
  logic        mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src;
  logic [2:0]  ALUctrl;
  logic        alu_src_b;
  logic [2:0]  imm_src;
  logic        reg_write;
  logic [1:0]  result_src;
  logic        retire, illegal, bus_err;

  mc_ctrl_fsm #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .instr(instr), .EQ(EQ), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_src(mem_addr_src),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .ALUctrl(ALUctrl), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .reg_write(reg_write), .result_src(result_src), .retire(retire),
    .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    ph = P_FETCH;
  int    waits = 0;
  bit    m_ill = 1'b0;
  bit    m_berr = 1'b0;
  int    req_run = 0;
  int    fetch_delay = 0;
  int    mem_delay = 0;
  bit    ack_random = 1'b0;
  outs_t last_out;
  outs_t outs_q[$];
  logic [2:0] f3_tab [4] = '{3'd0, 3'd7, 3'd6, 3'd2};

  function automatic int classify(input logic [31:0] w);
    logic [2:0] f3;
    bit alu_ok;
    f3 = w[14:12];
    alu_ok = (f3 == 3'd0) || (f3 == 3'd7) || (f3 == 3'd6) || (f3 == 3'd2);
    case (w[6:0])
      7'h33:   return alu_ok ? C_R : C_BAD;
      7'h13:   return alu_ok ? C_I : C_BAD;
      7'h03:   return (f3 == 3'd2) ? C_LW : C_BAD;
      7'h23:   return (f3 == 3'd2) ? C_SW : C_BAD;
      7'h63:   return (f3 <= 3'd1) ? C_BR : C_BAD;
      7'h6F:   return C_JAL;
      7'h37:   return C_LUI;
      default: return C_BAD;
    endcase
  endfunction

  function automatic logic [2:0] alu_exp(input logic [2:0] f3, input logic sub);
    case (f3)
      3'd0:    return sub ? 3'b001 : 3'b000;
      3'd7:    return 3'b010;
      3'd6:    return 3'b011;
      default: return 3'b101;
    endcase
  endfunction

  function automatic string pname(input int p);
    case (p)
      P_FETCH:  return "fetch";
      P_DECODE: return "decode";
      P_EXEC:   return "exec";
      P_MEM:    return "mem";
      P_WB:     return "wb";
      default:  return "trap";
    endcase
  endfunction

  // Reference: expected outputs for this cycle, then advance to the phase after the edge
  task automatic model_step(output outs_t w);
    int k;
    logic [2:0] f3;
    k  = classify(instr);
    f3 = instr[14:12];
    w  = '0;
    if (rst) begin
      ph = P_FETCH; waits = 0; m_ill = 1'b0; m_berr = 1'b0;
      return;
    end
    case (ph)
      P_FETCH, P_MEM: begin
        w.mem_req = 1'b1;
        if (ph == P_MEM) begin
          w.mem_addr_src = 1'b1;
          w.mem_we = (k == C_SW);
        end
        if (mem_ack) begin
          waits = 0;
          if (ph == P_FETCH) begin
            w.ir_write = 1'b1; ph = P_DECODE;
          end else if (k == C_SW) begin
            w.pc_write = 1'b1; w.retire = 1'b1; ph = P_FETCH;
          end else begin
            ph = P_WB;
          end
        end else if (waits == TIMEOUT - 1) begin
          ph = P_TRAP; m_berr = 1'b1;
        end else begin
          waits++;
        end
      end
      P_DECODE: begin
        if (k == C_BAD) begin
          ph = P_TRAP; m_ill = 1'b1;
        end else if (k == C_JAL) begin
          w.imm = 3'b011; w.reg_write = 1'b1; w.res = 2'b10;
          w.pc_write = 1'b1; w.pc_src = 1'b1; w.retire = 1'b1; ph = P_FETCH; waits = 0;
        end else if (k == C_LUI) begin
          w.imm = 3'b100; w.reg_write = 1'b1; w.res = 2'b11;
          w.pc_write = 1'b1; w.retire = 1'b1; ph = P_FETCH; waits = 0;
        end else begin
          ph = P_EXEC;
        end
      end
      P_EXEC: begin
        if (k == C_BR) begin
          w.alu = 3'b001; w.imm = 3'b010; w.pc_write = 1'b1;
          w.pc_src = EQ ^ (f3 == 3'd1); w.retire = 1'b1; ph = P_FETCH; waits = 0;
        end else if (k == C_LW || k == C_SW) begin
          w.alu_src_b = 1'b1; w.imm = (k == C_SW) ? 3'b001 : 3'b000; ph = P_MEM; waits = 0;
        end else if (k == C_I) begin
          w.alu = alu_exp(f3, 1'b0); w.alu_src_b = 1'b1; ph = P_WB;
        end else begin
          w.alu = alu_exp(f3, instr[30]); ph = P_WB;
        end
      end
      P_WB: begin
        w.reg_write = 1'b1; w.res = (k == C_LW) ? 2'b01 : 2'b00;
        w.pc_write = 1'b1; w.retire = 1'b1; ph = P_FETCH; waits = 0;
      end
      default: begin
        w.illegal = m_ill; w.bus_err = m_berr;
      end
    endcase
  endtask

  task automatic check_output(input outs_t got, input outs_t want, input string where);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL cycle_%0d_%s: got %h want %h (instr %h ack %b EQ %b)",
               cyc, where, got, want, instr, mem_ack, EQ);
    end
  endtask

  task automatic check_lit(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // One clock: choose ack, compare at the falling edge, then move past the rising edge
  task automatic tick();
    outs_t want, got;
    string where;
    #1;
    if (ack_random) mem_ack = ($urandom_range(0, 3) == 0);
    else mem_ack = mem_req && (req_run >= (mem_addr_src ? mem_delay : fetch_delay));
    @(negedge clk);
    got = {mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src, ALUctrl,
           alu_src_b, imm_src, reg_write, result_src, retire, illegal, bus_err};
    where = rst ? "reset" : pname(ph);
    model_step(want);
    check_output(got, want, where);
    last_out = got;
    if (rst || !mem_req || mem_ack) req_run = 0;
    else req_run++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Run one instruction until it retires or traps; optionally reset partway through
  task automatic run_instr(output int n, input int abort_at);
    bit done;
    done = 1'b0;
    n = 0;
    outs_q.delete();
    while (!done) begin
      if (n == abort_at) rst = 1'b1;
      tick();
      n++;
      outs_q.push_back(last_out);
      if (rst) begin
        rst = 1'b0; done = 1'b1;
      end else if (last_out.retire || last_out.illegal || last_out.bus_err) begin
        done = 1'b1;
      end else if (n >= 100) begin
        total++; bad++;
        $display("[TB] FAIL no_progress: got %0d cycles without retire, want under 100", n);
        done = 1'b1;
      end
    end
  endtask

  function automatic int count_where(input int which);
    int c;
    c = 0;
    foreach (outs_q[i]) begin
      case (which)
        0:       c += int'(outs_q[i].mem_req);
        1:       c += int'(outs_q[i].reg_write);
        2:       c += int'(outs_q[i].retire);
        3:       c += int'(outs_q[i].pc_write);
        4:       c += int'(outs_q[i].illegal);
        default: c += int'(outs_q[i].bus_err);
      endcase
    end
    return c;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int pick;
    w = $urandom;
    pick = $urandom_range(0, 19);
    if (pick <= 3) begin w[6:0] = 7'h33; w[14:12] = f3_tab[$urandom_range(0, 3)]; end
    else if (pick <= 6) begin w[6:0] = 7'h13; w[14:12] = f3_tab[$urandom_range(0, 3)]; end
    else if (pick <= 8) begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
    else if (pick <= 10) begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
    else if (pick <= 13) begin w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(0, 1)); end
    else if (pick == 14) w[6:0] = 7'h6F;
    else if (pick == 15) w[6:0] = 7'h37;
    else if (pick == 16) w[6:0] = 7'h33;
    return w;
  endfunction

  function automatic int pick_delay();
    if ($urandom_range(0, 9) == 0) return $urandom_range(0, 40);
    return $urandom_range(0, 3);
  endfunction

  // Randomised instruction mix, wait states, occasional timeouts and mid-flight resets
  task automatic apply_stimulus();
    int n, abort_at;
    for (int i = 0; i < 400; i++) begin
      instr       = rand_instr();
      EQ          = 1'($urandom_range(0, 1));
      fetch_delay = pick_delay();
      mem_delay   = pick_delay();
      ack_random  = ($urandom_range(0, 3) == 0);
      abort_at    = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 6) : -1;
      run_instr(n, abort_at);
      if (last_out.illegal || last_out.bus_err) begin
        repeat ($urandom_range(1, 4)) tick();
        apply_reset();
      end
    end
    ack_random = 1'b0;
  endtask

  initial begin
    int n, c;
    rst = 1'b1; instr = 32'h0; EQ = 1'b0; mem_ack = 1'b0;
    last_out = '0;

    $display("[TB] reset and add x3,x1,x2");
    apply_reset();
    check_lit("reset_quiet", int'(last_out), 0);
    instr = 32'h002081B3;
    run_instr(n, -1);
    check_lit("add_latency", n, 4);
    check_lit("add_exec_alu", int'(outs_q[2].alu), 0);
    check_lit("add_wb_strobes", int'({outs_q[3].reg_write, outs_q[3].pc_write, outs_q[3].retire}), 7);
    check_lit("add_retire_count", count_where(2), 1);
    check_lit("add_reg_write_count", count_where(1), 1);

    $display("[TB] branches");
    instr = 32'h00208463; EQ = 1'b1;
    run_instr(n, -1);
    check_lit("beq_taken_latency", n, 3);
    check_lit("beq_taken_exec", int'({outs_q[2].alu, outs_q[2].pc_write, outs_q[2].pc_src}), 5'b00111);
    EQ = 1'b0;
    run_instr(n, -1);
    check_lit("beq_not_taken_pc_src", int'({outs_q[2].pc_write, outs_q[2].pc_src}), 2'b10);
    instr = 32'h00209463; EQ = 1'b1;
    run_instr(n, -1);
    check_lit("bne_eq_pc_src", int'({outs_q[2].pc_write, outs_q[2].pc_src}), 2'b10);

    $display("[TB] lw with three wait states");
    instr = 32'h0000A183; mem_delay = 3;
    run_instr(n, -1);
    check_lit("lw_latency", n, 8);
    c = 0;
    for (int i = 3; i < 7; i++) c += int'(outs_q[i].mem_req && outs_q[i].mem_addr_src);
    check_lit("lw_mem_req_held", c, 4);
    check_lit("lw_wb_result", int'({outs_q[7].res, outs_q[7].reg_write}), 3'b011);
    mem_delay = 0;

    $display("[TB] sw");
    instr = 32'h0020A023;
    run_instr(n, -1);
    check_lit("sw_latency", n, 4);
    check_lit("sw_exec_imm", int'(outs_q[2].imm), 1);
    check_lit("sw_mem_we_retire", int'({outs_q[3].mem_we, outs_q[3].retire}), 2'b11);
    check_lit("sw_no_reg_write", count_where(1), 0);

    $display("[TB] illegal opcode");
    instr = 32'h0000007F;
    run_instr(n, -1);
    check_lit("ill_latency", n, 3);
    outs_q.delete();
    repeat (20) begin tick(); outs_q.push_back(last_out); end
    check_lit("ill_no_req", count_where(0), 0);
    check_lit("ill_held", count_where(4), 20);
    apply_reset();
    tick();
    check_lit("ill_cleared", int'({last_out.mem_req, last_out.illegal}), 2'b10);
    apply_reset();

    $display("[TB] fetch timeout");
    instr = 32'h002081B3; fetch_delay = 1000;
    run_instr(n, -1);
    check_lit("timeout_latency", n, 17);
    check_lit("timeout_req_cycles", count_where(0), 16);
    check_lit("timeout_bus_err", int'(last_out.bus_err), 1);
    apply_reset();
    fetch_delay = 15;
    run_instr(n, -1);
    check_lit("ack_last_cycle_latency", n, 19);
    check_lit("ack_last_cycle_no_bus_err", count_where(5), 0);
    fetch_delay = 0;

    $display("[TB] reset during MEM");
    instr = 32'h0000A183; mem_delay = 1000;
    run_instr(n, 4);
    check_lit("abort_reset_quiet", int'(last_out), 0);
    tick();
    check_lit("abort_back_to_fetch",
              int'({last_out.mem_req, last_out.mem_addr_src, last_out.pc_write, last_out.retire}), 4'b1000);
    mem_delay = 0;
    apply_reset();

    $display("[TB] random sequence");
    apply_stimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(10 * 80000);
    $display("[TB] FAIL watchdog: got no completion after 80000 cycles, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
